mul3_serial_tx: RTL

MUL3_SERIAL_TX -- requirements
Module: mul3_serial_tx

---
 rtl/mul3_pkg.sv | 12 +
 rtl/serial_add_cell.sv | 31 +++
 rtl/mul3_serial_tx.sv | 112 +++++++++++
 3 files changed

// File: rtl/mul3_pkg.sv
// Shared definitions for the serial times-three transmitter.
package mul3_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_W = 8;

endpackage

// File: rtl/serial_add_cell.sv
// One-bit serial adder: combinational 3-input sum, registered carry.
module serial_add_cell (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic a,
  input  logic b,
  output logic sum
);

  logic carry;
  logic c_eff;

  // clr zeroes the carry entering this bit, so clr with en starts a fresh sum here.
  always_comb begin
    c_eff = clr ? 1'b0 : carry;
    sum   = a ^ b ^ c_eff;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      carry <= 1'b0;
    end else if (en) begin
      carry <= (a & b) | (c_eff & (a ^ b));
    end else if (clr) begin
      carry <= 1'b0;
    end
  end

endmodule

// File: rtl/mul3_serial_tx.sv
// Streams 3*din LSB first as x + (x << 1), one bit per clock, then pulses done.
module mul3_serial_tx
  import mul3_pkg::*;
#(
  parameter  int unsigned W     = DEFAULT_W,
  localparam int unsigned OUT_W = W + 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] din,
  output logic         sout,
  output logic         sout_valid,
  output logic         busy,
  output logic         done
);

  localparam int unsigned CW = $clog2(OUT_W + 1);

  state_t         state, state_next;
  logic [W-1:0]   sh, sh_next;
  logic           prev, prev_next;
  logic [CW-1:0]  cnt, cnt_next;
  logic           sout_next, valid_next, busy_next, done_next;
  logic           cell_a, cell_b, cell_clr, cell_en, cell_sum;

  serial_add_cell u_add (
    .clk   (clk),
    .reset (reset),
    .clr   (cell_clr),
    .en    (cell_en),
    .a     (cell_a),
    .b     (cell_b),
    .sum   (cell_sum)
  );

  always_comb begin
    state_next = state;
    sh_next    = sh;
    prev_next  = prev;
    cnt_next   = cnt;
    sout_next  = 1'b0;
    valid_next = 1'b0;
    busy_next  = 1'b0;
    done_next  = 1'b0;
    cell_a     = 1'b0;
    cell_b     = 1'b0;
    cell_clr   = 1'b0;
    cell_en    = 1'b0;

    case (state)
      SEND: begin
        busy_next = 1'b1;
        cell_a    = sh[0];
        cell_b    = prev;
        if (cnt == CW'(OUT_W - 1)) begin
          state_next = DONE;
          done_next  = 1'b1;
        end else begin
          cell_en    = 1'b1;
          sh_next    = sh >> 1;
          prev_next  = sh[0];
          cnt_next   = cnt + CW'(1);
          sout_next  = cell_sum;
          valid_next = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        // Bit 0 is produced on the accept edge so it is visible in the next cycle.
        if (start) begin
          state_next = SEND;
          cell_a     = din[0];
          cell_clr   = 1'b1;
          cell_en    = 1'b1;
          sh_next    = din >> 1;
          prev_next  = din[0];
          cnt_next   = '0;
          sout_next  = cell_sum;
          valid_next = 1'b1;
          busy_next  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      sh         <= '0;
      prev       <= 1'b0;
      cnt        <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      sh         <= sh_next;
      prev       <= prev_next;
      cnt        <= cnt_next;
      sout       <= sout_next;
      sout_valid <= valid_next;
      busy       <= busy_next;
      done       <= done_next;
    end
  end

endmodule
